ysyx_040066_mem_arbiter: RTL and testbench
==========================================

# ysyx_040066_mem_arbiter

Parametrised memory-port arbiter that merges NUM_RD cache refill read channels and one cache write-back channel onto a single beat-level downstream memory port. It sits between the icache/dcache miss interfaces and the AXI-side bridge, replacing the fixed one-instruction-port, one-data-port wiring with round-robin arbitration, write-line serialisation and error forwarding. One transaction is in flight at a time; every transaction runs to completion or error before the next grant.

## Interface
- NUM_RD, 2, number of read request channels (≥1); channel 0 = icache, 1 = dcache
- DATA_W, 64, beat width in bits
- ADDR_W, 64, address width
- LINE_BEATS, 8, beats per cache line; LEN_W = $clog2(LINE_BEATS)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_req  in  NUM_RD  per-channel read request, held until rd_last or rd_err
- rd_burst  in  NUM_RD  1 = burst of rd_len+1 beats, 0 = single beat
- rd_len  in  NUM_RD*LEN_W  beats minus one, channel i at [i*LEN_W+:LEN_W]
- rd_addr  in  NUM_RD*ADDR_W  start address, channel i at [i*ADDR_W+:ADDR_W]
- rd_ready  out  NUM_RD  beat valid to owner
- rd_last  out  NUM_RD  final beat to owner
- rd_err  out  NUM_RD  error to owner
- rd_data  out  DATA_W  broadcast of m_rdata
- wr_req, wr_burst  in  1 each  write request / burst flag
- wr_len  in  LEN_W  beats minus one
- wr_mask  in  DATA_W/8  byte mask, applied to every beat
- wr_addr  in  ADDR_W  start address
- wr_data  in  DATA_W*LINE_BEATS  whole line, beat k at [k*DATA_W+:DATA_W]
- wr_ready, wr_err  out  1 each  single-cycle completion / error pulse
- m_req, m_we, m_burst  out  1 each  downstream request, write enable, burst
- m_len  out  LEN_W; m_addr  out  ADDR_W; m_wmask  out  DATA_W/8
- m_wdata  out  DATA_W  current write beat; m_wlast  out  1  current beat is final
- m_ready  in  1  beat accepted (write) / beat valid (read)
- m_last, m_err  in  1 each  final read beat / transaction error
- m_rdata  in  DATA_W  read beat

## Operation
- States: IDLE, RD (owner index latched), WR.
- IDLE: select one pending requester by round-robin from pointer ptr over N = NUM_RD+1 slots (slot NUM_RD = write); latch owner, burst, len, addr, mask; go RD/WR. No request: stay.
- After granting slot c, ptr <= (c+1) mod N.
- m_req/m_we/m_burst/m_len/m_addr/m_wmask are registered, stable for whole transaction.
- RD: rd_ready[owner] = m_ready, rd_last[owner] = m_ready&&m_last, rd_err[owner] = m_err; non-owners 0. Done on m_ready&&m_last or m_err -> IDLE.
- WR: beat counter k from 0; m_wdata = wr_data beat k; m_wlast = (k==len), k=0 for single. On m_ready: k++; on m_ready&&m_wlast: wr_ready pulse -> IDLE. m_err: wr_err pulse -> IDLE.
- m_err ends any transaction on the cycle it is seen, regardless of m_ready.
- Requester dropping req mid-transaction is ignored; transaction completes downstream.
- Read len > LINE_BEATS-1 impossible by width; m_last before len+1 beats honoured (terminates).

## Timing
- Reset (async, rst=0): state IDLE, ptr 0, k 0, all outputs 0 immediately, no clock needed.
- Grant latency: req high at edge t -> m_req high after edge t (one cycle).
- Completion beat at edge t -> m_req low after t; earliest next grant after t+1 (one dead cycle minimum).
- rd_*/wr_ready/wr_err upstream responses combinational from m_ready/m_last/m_err in same cycle.
- Back-to-back m_ready: one beat per cycle; 8-beat burst, zero wait = 8 cycles of m_req plus 1 grant cycle.

## Configuration
- YSYX_040066_ARB_WR_PRIO_EN defined: write slot wins over all reads whenever wr_req is high in IDLE; reads round-robin among themselves only (ptr over NUM_RD); ptr unchanged by write grants.
- Undefined: write is ordinary round-robin slot NUM_RD as described above.

## Test plan
- Ch0 read, burst, len 7, m_ready every cycle, m_last on 8th -> rd_ready[0] 8 pulses, rd_last[0] on 8th, rd_data == m_rdata, m_req low next cycle, rd_ready[1] stays 0.
- rd_req = 2'b11 held from reset, single beats -> grants ch0, ch1, ch0, ch1; m_addr alternates rd_addr0/rd_addr1.
- Write len 7, beat k = 64'h0101_0101_0101_0101*k, m_ready every other cycle -> m_wdata sequence 0..7, m_wlast with beat 7, one wr_ready pulse, m_wmask == wr_mask throughout.
- Ch1 burst read, m_err on 3rd beat -> rd_err[1] that cycle, no rd_last, m_req low next cycle, ch0 pending request granted after.
- wr_req and rd_req[0] both high, ptr 0: with YSYX_040066_ARB_WR_PRIO_EN -> write first; without -> read ch0 first, then write.
- rst low mid-burst (between clocks) -> m_req and rd_ready 0 at once; after release with rd_req=2'b10 -> ch1 granted one cycle later, ptr restarted from 0.

Source files
------------

// File: rtl/ysyx_040066_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_040066_mem_arbiter
//
// Merges NUM_RD cache-refill read channels (0 = icache, 1 = dcache) and one
// cache write-back channel onto a single beat-level downstream memory port.
// Only one transaction is in flight at a time. Each transaction runs until it
// completes or errors, and only then is the next requester granted.
//
// Arbitration: round-robin over N slots from pointer ptr. Slots 0..NUM_RD-1
// are the read channels and slot NUM_RD is the write channel. After slot c is
// granted, ptr becomes (c+1) mod N.
//
// Optional feature macro: YSYX_040066_ARB_WR_PRIO_EN
//   When it is defined, a pending write beats every read in IDLE. Reads then
//   round-robin among themselves only, and a write grant leaves ptr unchanged.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   rd_req/burst/len/addr      per-channel read requests (packed per channel)
//   rd_ready/last/err          per-channel read responses, owner only
//   rd_data                    broadcast of m_rdata
//   wr_req/burst/len/mask/addr write-back request
//   wr_data                    whole line, beat k at [k*DATA_W +: DATA_W]
//   wr_ready, wr_err           single-cycle completion / error pulses
//   m_req/we/burst/len/addr/wmask  registered downstream request fields
//   m_wdata, m_wlast           current write beat and its last flag
//   m_ready, m_last, m_err     downstream handshake / last beat / error
//   m_rdata                    downstream read beat
// ---------------------------------------------------------------------------
module ysyx_040066_mem_arbiter #(
    parameter int NUM_RD     = 2,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int LINE_BEATS = 8,
    parameter int LEN_W      = $clog2(LINE_BEATS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD-1:0]            rd_burst,
    input  logic [NUM_RD*LEN_W-1:0]      rd_len,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD-1:0]            rd_ready,
    output logic [NUM_RD-1:0]            rd_last,
    output logic [NUM_RD-1:0]            rd_err,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         wr_req,
    input  logic                         wr_burst,
    input  logic [LEN_W-1:0]             wr_len,
    input  logic [DATA_W/8-1:0]          wr_mask,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W*LINE_BEATS-1:0] wr_data,
    output logic                         wr_ready,
    output logic                         wr_err,
    output logic                         m_req,
    output logic                         m_we,
    output logic                         m_burst,
    output logic [LEN_W-1:0]             m_len,
    output logic [ADDR_W-1:0]            m_addr,
    output logic [DATA_W/8-1:0]          m_wmask,
    output logic [DATA_W-1:0]            m_wdata,
    output logic                         m_wlast,
    input  logic                         m_ready,
    input  logic                         m_last,
    input  logic                         m_err,
    input  logic [DATA_W-1:0]            m_rdata
);

    localparam int SLOT_W = $clog2(NUM_RD + 1);
    localparam int MASK_W = DATA_W / 8;
`ifdef YSYX_040066_ARB_WR_PRIO_EN
    localparam int RR_N = NUM_RD;
`else
    localparam int RR_N = NUM_RD + 1;
`endif
    localparam logic [SLOT_W-1:0] WR_SLOT = SLOT_W'(NUM_RD);
    localparam logic [SLOT_W-1:0] RR_TOP  = SLOT_W'(RR_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   ptr_q, ptr_d;
    logic [SLOT_W-1:0]   owner_q, owner_d;
    logic                burst_q, burst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [LEN_W-1:0]    beat_q, beat_d;

    // -----------------------------------------------------------------------
    // Requester selection (only used in IDLE)
    // -----------------------------------------------------------------------
    logic [NUM_RD:0]     pending;
    logic                grant_vld;
    logic [SLOT_W-1:0]   grant_slot;
    logic [SLOT_W-1:0]   grant_ptr;
    logic                sel_burst;
    logic [LEN_W-1:0]    sel_len;
    logic [ADDR_W-1:0]   sel_addr;

    // NOTE: every signal driven here gets a default before any conditional
    // logic, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pending    = {wr_req, rd_req};
        grant_vld  = 1'b0;
        grant_slot = '0;
`ifdef YSYX_040066_ARB_WR_PRIO_EN
        if (wr_req) begin
            grant_vld  = 1'b1;
            grant_slot = WR_SLOT;
        end
`endif
        // The first pass takes the lowest pending slot at or above ptr. The
        // second pass wraps around to slot 0. Together they give the first
        // pending slot in the circular order ptr, ptr+1, ...
        for (int j = 0; j < RR_N; j++) begin
            if (!grant_vld && pending[j] && (SLOT_W'(j) >= ptr_q)) begin
                grant_vld  = 1'b1;
                grant_slot = SLOT_W'(j);
            end
        end
        for (int j = 0; j < RR_N; j++) begin
            if (!grant_vld && pending[j]) begin
                grant_vld  = 1'b1;
                grant_slot = SLOT_W'(j);
            end
        end

        grant_ptr = (grant_slot == RR_TOP) ? '0 : grant_slot + 1'b1;

        sel_burst = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (grant_slot == SLOT_W'(i)) begin
                sel_burst = rd_burst[i];
                sel_len   = rd_len[i*LEN_W +: LEN_W];
                sel_addr  = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        len_d   = len_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        req_d   = req_q;
        we_d    = we_q;
        beat_d  = beat_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_slot;
                    req_d   = 1'b1;
                    beat_d  = '0;
                    if (grant_slot == WR_SLOT) begin
                        state_d = WR;
                        we_d    = 1'b1;
                        burst_d = wr_burst;
                        len_d   = wr_len;
                        addr_d  = wr_addr;
                        mask_d  = wr_mask;
                    end else begin
                        state_d = RD;
                        we_d    = 1'b0;
                        burst_d = sel_burst;
                        len_d   = sel_len;
                        addr_d  = sel_addr;
                        mask_d  = '0;
                    end
`ifdef YSYX_040066_ARB_WR_PRIO_EN
                    if (grant_slot != WR_SLOT) begin
                        ptr_d = grant_ptr;
                    end
`else
                    ptr_d = grant_ptr;
`endif
                end
            end
            RD: begin
                // An early m_last is honoured, so a read may end before len+1 beats.
                if (m_err || (m_ready && m_last)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            WR: begin
                if (m_err || (m_ready && m_wlast)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    beat_d  = '0;
                end else if (m_ready) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every
    // flop samples its pre-edge value, whatever order the blocks evaluate in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            req_q   <= req_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: downstream fields come from registers; upstream responses
    // pass straight through from the downstream handshake in the same cycle.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] wdata_beat;

    always_comb begin
        rd_ready = '0;
        rd_last  = '0;
        rd_err   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ((state_q == RD) && (owner_q == SLOT_W'(i))) begin
                rd_ready[i] = m_ready;
                rd_last[i]  = m_ready && m_last;
                rd_err[i]   = m_err;
            end
        end

        wdata_beat = '0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            if (beat_q == LEN_W'(k)) begin
                wdata_beat = wr_data[k*DATA_W +: DATA_W];
            end
        end

        // A single-beat write ends on beat 0 whatever wr_len says.
        m_wlast  = (state_q == WR) && (burst_q ? (beat_q == len_q) : (beat_q == '0));
        m_wdata  = (state_q == WR) ? wdata_beat : '0;
        wr_ready = (state_q == WR) && m_ready && m_wlast;
        wr_err   = (state_q == WR) && m_err;
    end

    assign rd_data = m_rdata;
    assign m_req   = req_q;
    assign m_we    = we_q;
    assign m_burst = burst_q;
    assign m_len   = len_q;
    assign m_addr  = addr_q;
    assign m_wmask = mask_q;

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_040066_mem_arbiter.
// The phases are: a grant-order table, hand-written multi-cycle sequences
// (burst read, write line, error abort, priority, async reset mid-burst)
// and random transactions checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_ysyx_040066_mem_arbiter;

    localparam int NUM_RD     = 2;
    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 64;
    localparam int LINE_BEATS = 8;
    localparam int LEN_W      = 3;
    localparam int MASK_W     = DATA_W / 8;
    localparam int WRS        = NUM_RD;   // write slot index

    logic                         clk;
    logic                         rst;
    logic [NUM_RD-1:0]            rd_req, rd_burst;
    logic [NUM_RD*LEN_W-1:0]      rd_len;
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD-1:0]            rd_ready, rd_last, rd_err;
    logic [DATA_W-1:0]            rd_data;
    logic                         wr_req, wr_burst;
    logic [LEN_W-1:0]             wr_len;
    logic [MASK_W-1:0]            wr_mask;
    logic [ADDR_W-1:0]            wr_addr;
    logic [DATA_W*LINE_BEATS-1:0] wr_data;
    logic                         wr_ready, wr_err;
    logic                         m_req, m_we, m_burst;
    logic [LEN_W-1:0]             m_len;
    logic [ADDR_W-1:0]            m_addr;
    logic [MASK_W-1:0]            m_wmask;
    logic [DATA_W-1:0]            m_wdata;
    logic                         m_wlast;
    logic                         m_ready, m_last, m_err;
    logic [DATA_W-1:0]            m_rdata;

    ysyx_040066_mem_arbiter #(
        .NUM_RD(NUM_RD), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .LINE_BEATS(LINE_BEATS), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_last(rd_last), .rd_err(rd_err), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .m_req(m_req), .m_we(m_we), .m_burst(m_burst), .m_len(m_len),
        .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_ready(m_ready), .m_last(m_last), .m_err(m_err), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int model_ptr;
    logic [DATA_W-1:0] wline [LINE_BEATS];

    typedef struct {
        logic [NUM_RD-1:0] rd;
        logic              wr;
        int                slot;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic slot_burst(input int s);
        return (s == WRS) ? wr_burst : rd_burst[s];
    endfunction

    function automatic logic [LEN_W-1:0] slot_len(input int s);
        return (s == WRS) ? wr_len : rd_len[s*LEN_W +: LEN_W];
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input int s);
        return (s == WRS) ? wr_addr : rd_addr[s*ADDR_W +: ADDR_W];
    endfunction

    // Reference arbitration: scan slots in circular order starting at ptr.
    function automatic int model_pick(input logic [NUM_RD:0] pend);
`ifdef YSYX_040066_ARB_WR_PRIO_EN
        if (pend[WRS]) return WRS;
        for (int i = 0; i < NUM_RD; i++)
            if (pend[(model_ptr + i) % NUM_RD]) return (model_ptr + i) % NUM_RD;
`else
        for (int i = 0; i < NUM_RD + 1; i++)
            if (pend[(model_ptr + i) % (NUM_RD + 1)]) return (model_ptr + i) % (NUM_RD + 1);
`endif
        return -1;
    endfunction

    function automatic void model_update(input int win);
`ifdef YSYX_040066_ARB_WR_PRIO_EN
        if (win != WRS) model_ptr = (win + 1) % NUM_RD;
`else
        model_ptr = (win + 1) % (NUM_RD + 1);
`endif
    endfunction

    task automatic pack_line();
        for (int k = 0; k < LINE_BEATS; k++) wr_data[k*DATA_W +: DATA_W] = wline[k];
    endtask

    task automatic idle_inputs();
        rd_req = '0; rd_burst = '0; rd_len = '0; rd_addr = '0;
        wr_req = 1'b0; wr_burst = 1'b0; wr_len = '0; wr_mask = '0; wr_addr = '0;
        m_ready = 1'b0; m_last = 1'b0; m_err = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rd_req = '0; wr_req = 1'b0;
        m_ready = 1'b0; m_last = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
    endtask

    // Called before a rising edge. Checks the registered request one cycle later.
    task automatic grant_check(input int s);
        @(posedge clk);
        @(negedge clk);
        check("m_req_grant", m_req, 1'b1);
        check("m_we_grant", m_we, s == WRS);
        check("m_burst_grant", m_burst, slot_burst(s));
        check("m_len_grant", m_len, slot_len(s));
        check("m_addr_grant", m_addr, slot_addr(s));
        if (s == WRS) check("m_wmask_grant", m_wmask, wr_mask);
    endtask

    // Acts as the downstream memory for the transaction owned by slot s.
    // mode 0: ready every cycle, 1: every other cycle, 2: random.
    // err_at: beat index on which m_err is raised (-1 = never).
    task automatic serve(input int s, input int mode, input int err_at);
        int beat, cyc, lim;
        bit rdy, err, done, is_wr;
        logic [NUM_RD-1:0] oh;
        beat = 0; cyc = 0; done = 0;
        is_wr = (s == WRS);
        lim = slot_burst(s) ? int'(slot_len(s)) : 0;
        oh = '0;
        if (!is_wr) oh[s] = 1'b1;
        forever begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = ($urandom_range(3) != 0);
            endcase
            err = (beat == err_at);
            m_ready = rdy;
            m_err   = err;
            m_last  = (beat == lim);
            m_rdata = {$urandom, $urandom};
            #1;
            done = err || (rdy && beat == lim);
            check("m_req_busy", m_req, 1'b1);
            if (is_wr) begin
                check("m_wdata", m_wdata, wline[beat]);
                check("m_wlast", m_wlast, beat == lim);
                check("wr_ready", wr_ready, rdy && beat == lim);
                check("wr_err", wr_err, err);
                check("m_wmask_hold", m_wmask, wr_mask);
                check("rd_ready_in_wr", rd_ready, '0);
            end else begin
                check("rd_ready", rd_ready, rdy ? oh : '0);
                check("rd_last", rd_last, (rdy && beat == lim) ? oh : '0);
                check("rd_err", rd_err, err ? oh : '0);
                check("rd_data", rd_data, m_rdata);
                check("wr_ready_in_rd", wr_ready, 1'b0);
                check("m_wlast_in_rd", m_wlast, 1'b0);
            end
            @(posedge clk);
            if (rdy) beat++;
            cyc++;
            if (done) break;
            if (cyc > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL serve_timeout: slot %0d still busy after %0d cycles", s, cyc);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        m_ready = 1'b0; m_last = 1'b0; m_err = 1'b0;
        #1;
        check("m_req_after_done", m_req, 1'b0);
        check("rd_ready_after_done", rd_ready, '0);
        check("wr_ready_after_done", wr_ready, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"}, m_req, 1'b0);
        check({tag, "_m_we"}, m_we, 1'b0);
        check({tag, "_m_burst"}, m_burst, 1'b0);
        check({tag, "_m_len"}, m_len, '0);
        check({tag, "_m_addr"}, m_addr, '0);
        check({tag, "_m_wmask"}, m_wmask, '0);
        check({tag, "_m_wdata"}, m_wdata, '0);
        check({tag, "_m_wlast"}, m_wlast, 1'b0);
        check({tag, "_rd_ready"}, rd_ready, '0);
        check({tag, "_rd_last"}, rd_last, '0);
        check({tag, "_rd_err"}, rd_err, '0);
        check({tag, "_wr_ready"}, wr_ready, 1'b0);
        check({tag, "_wr_err"}, wr_err, 1'b0);
    endtask

    // A ch0 burst is in progress (ptr already 1) when reset hits between edges.
    task automatic mid_reset_case(input logic [NUM_RD-1:0] rel_req, input int exp_slot);
        rd_req = 2'b01; wr_req = 1'b0;
        rd_burst = 2'b01;
        rd_len = {3'd0, 3'd7};
        rd_addr = {64'h0000_0000_8000_1100, 64'h0000_0000_8000_2200};
        grant_check(0);
        m_ready = 1'b1; m_last = 1'b0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        m_last = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check("rst_held_m_req", m_req, 1'b0);
        @(negedge clk);
        m_ready = 1'b0; m_last = 1'b0;
        rd_req = rel_req;
        rst = 1'b1;
        #1;
        check("rst_release_m_req", m_req, 1'b0);
        grant_check(exp_slot);
        serve(exp_slot, 0, -1);
        rd_req = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_RD:0] pend;
        int win, lim, err_at, s1, s2;

        n_checks = 0;
        n_errors = 0;
        model_ptr = 0;
        for (int k = 0; k < LINE_BEATS; k++) wline[k] = '0;
        idle_inputs();
        wr_data = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_all_zero("por");
        do_reset();

        // With no request pending, nothing is granted.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_m_req", m_req, 1'b0);
        end

        // ---------------- grant-order table (single beats) ----------------
`ifdef YSYX_040066_ARB_WR_PRIO_EN
        tbl[0] = '{2'b11, 1'b0, 0};
        tbl[1] = '{2'b11, 1'b0, 1};
        tbl[2] = '{2'b11, 1'b0, 0};
        tbl[3] = '{2'b11, 1'b0, 1};
        tbl[4] = '{2'b01, 1'b1, 2};
        tbl[5] = '{2'b01, 1'b1, 2};
        tbl[6] = '{2'b01, 1'b1, 2};
        tbl[7] = '{2'b10, 1'b0, 1};
        tbl[8] = '{2'b00, 1'b1, 2};
        tbl[9] = '{2'b10, 1'b1, 2};
`else
        tbl[0] = '{2'b11, 1'b0, 0};
        tbl[1] = '{2'b11, 1'b0, 1};
        tbl[2] = '{2'b11, 1'b0, 0};
        tbl[3] = '{2'b11, 1'b0, 1};
        tbl[4] = '{2'b01, 1'b1, 2};
        tbl[5] = '{2'b01, 1'b1, 0};
        tbl[6] = '{2'b01, 1'b1, 2};
        tbl[7] = '{2'b10, 1'b0, 1};
        tbl[8] = '{2'b00, 1'b1, 2};
        tbl[9] = '{2'b10, 1'b1, 1};
`endif
        rd_addr  = {64'h0000_0000_B000_0040, 64'h0000_0000_A000_0080};
        wr_addr  = 64'h0000_0000_C000_00C0;
        rd_burst = 2'b00;
        wr_burst = 1'b0;
        rd_len   = {3'd5, 3'd2};
        wr_len   = 3'd4;
        wr_mask  = 8'h5A;
        for (int k = 0; k < LINE_BEATS; k++) wline[k] = 64'hDEAD_0000_0000_0000 + 64'(k);
        pack_line();
        for (int i = 0; i < 10; i++) begin
            rd_req = tbl[i].rd;
            wr_req = tbl[i].wr;
            grant_check(tbl[i].slot);
            serve(tbl[i].slot, 0, -1);
        end
        rd_req = '0;
        wr_req = 1'b0;

        // ---------------- hand-written sequences ----------------
        do_reset();
        // ch0 8-beat burst with zero wait states
        rd_req = 2'b01;
        rd_burst = 2'b01;
        rd_len = {3'd0, 3'd7};
        rd_addr = {64'h0000_0000_8000_0200, 64'h0000_0000_8000_0100};
        grant_check(0);
        serve(0, 0, -1);
        rd_req = '0;

        // write line, ready every other cycle
        for (int k = 0; k < LINE_BEATS; k++) wline[k] = 64'h0101_0101_0101_0101 * 64'(k);
        pack_line();
        wr_burst = 1'b1;
        wr_len = 3'd7;
        wr_mask = 8'hC3;
        wr_addr = 64'h0000_0000_8000_0400;
        wr_req = 1'b1;
        grant_check(WRS);
        serve(WRS, 1, -1);
        wr_req = 1'b0;

        // ch1 burst aborted by m_err on its 3rd beat, while ch0 waits
        rd_req = 2'b10;
        rd_burst = 2'b10;
        rd_len = {3'd7, 3'd0};
        grant_check(1);
        rd_req = 2'b11;
        serve(1, 0, 2);
        rd_req = 2'b01;
        grant_check(0);
        serve(0, 0, -1);
        rd_req = '0;

        // write and ch0 read pending together with ptr at 0
        do_reset();
        rd_burst = 2'b00;
        wr_burst = 1'b0;
        rd_req = 2'b01;
        wr_req = 1'b1;
`ifdef YSYX_040066_ARB_WR_PRIO_EN
        s1 = WRS; s2 = 0;
`else
        s1 = 0; s2 = WRS;
`endif
        grant_check(s1);
        if (s1 == WRS) wr_req = 1'b0; else rd_req = '0;
        serve(s1, 0, -1);
        grant_check(s2);
        rd_req = '0;
        wr_req = 1'b0;
        serve(s2, 0, -1);

        // asynchronous reset in the middle of a burst
        mid_reset_case(2'b10, 1);
        mid_reset_case(2'b11, 0);

        // ---------------- random transactions vs model ----------------
        do_reset();
        for (int it = 0; it < 80; it++) begin
            rd_burst = NUM_RD'($urandom);
            rd_len   = (NUM_RD*LEN_W)'($urandom);
            rd_addr  = {$urandom, $urandom, $urandom, $urandom};
            wr_burst = 1'($urandom);
            wr_len   = LEN_W'($urandom);
            wr_mask  = MASK_W'($urandom);
            wr_addr  = {$urandom, $urandom};
            for (int k = 0; k < LINE_BEATS; k++) wline[k] = {$urandom, $urandom};
            pack_line();
            pend = (NUM_RD+1)'($urandom_range(2**(NUM_RD+1) - 1, 1));
            rd_req = pend[NUM_RD-1:0];
            wr_req = pend[NUM_RD];
            win = model_pick(pend);
            grant_check(win);
            model_update(win);
            // A requester may drop its request mid-transaction; it must not matter.
            if ($urandom_range(1) == 1) begin
                if (win == WRS) wr_req = 1'b0; else rd_req[win] = 1'b0;
            end
            lim = slot_burst(win) ? int'(slot_len(win)) : 0;
            err_at = ($urandom_range(5) == 0) ? int'($urandom_range(lim, 0)) : -1;
            serve(win, 2, err_at);
        end
        rd_req = '0;
        wr_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
